// File: rtl/lane_pkg.sv
// Shared types and colour constants for the road-lane stripe controller.
package lane_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    FLASH = 2'd3
  } lane_state_t;

  typedef struct packed {
    logic start;
    logic pause;
    logic speed_up;
    logic speed_dn;
    logic crash;
  } lane_events_t;

  localparam logic [5:0] COLOR_YELLOW = 6'b111100;
  localparam logic [5:0] COLOR_RED    = 6'b110000;
  localparam logic [5:0] COLOR_BLACK  = 6'b000000;

endpackage

// File: rtl/lane_event_latch.sv
// Sticky pending flags for the button pulses; consumed on the frame tick.
module lane_event_latch
  import lane_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  lane_events_t pulse,
  output lane_events_t pending
);

  lane_events_t flags_q;

  // A pulse arriving on the tick itself is seen through the OR path.
  assign pending = flags_q | pulse;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (tick) begin
      flags_q <= '0;
    end else begin
      flags_q <= pending;
    end
  end

endmodule

// File: rtl/lane_scroll_ctrl.sv
// Frame-synchronous lane stripe animator: run/pause/flash FSM, dash phase
// and speed counters, and a registered stripe pixel colour.
module lane_scroll_ctrl
  import lane_pkg::*;
#(
  parameter int unsigned LANE_BEGIN   = 275,
  parameter int unsigned LANE_WIDTH   = 35,
  parameter int unsigned DASH_PERIOD  = 64,
  parameter int unsigned DASH_LEN     = 32,
  parameter int unsigned MAX_SPEED    = 7,
  parameter int unsigned FLASH_FRAMES = 60,
  parameter int unsigned VIS_ROWS     = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] col,
  input  logic [9:0] row,
  input  logic       valid,
  input  logic       start,
  input  logic       pause,
  input  logic       speed_up,
  input  logic       speed_dn,
  input  logic       crash,
  output logic [5:0] lane_rgb,
  output logic [5:0] phase,
  output logic [2:0] speed,
  output logic [1:0] state
);

  lane_state_t  state_q, state_d;
  logic [5:0]   phase_q, phase_d;
  logic [2:0]   speed_q, speed_d;
  logic [5:0]   flash_q, flash_d;
  logic [5:0]   rgb_q, rgb_d;
  lane_events_t pulse, ev;
  logic         frame_tick;

  assign frame_tick = (row == 10'(VIS_ROWS)) && (col == 10'd0);
  assign pulse      = '{start: start, pause: pause, speed_up: speed_up,
                        speed_dn: speed_dn, crash: crash};

  lane_event_latch u_event_latch (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (frame_tick),
    .pulse   (pulse),
    .pending (ev)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    speed_d = speed_q;
    flash_d = flash_q;
    if (frame_tick) begin
      if (ev.speed_up && !ev.speed_dn && speed_q != 3'(MAX_SPEED)) begin
        speed_d = speed_q + 3'd1;
      end else if (ev.speed_dn && !ev.speed_up && speed_q != 3'd0) begin
        speed_d = speed_q - 3'd1;
      end
      if (ev.crash) begin
        state_d = FLASH;
        flash_d = 6'(FLASH_FRAMES - 1);
      end else begin
        unique case (state_q)
          IDLE:  if (ev.start) state_d = RUN;
          RUN:   if (ev.pause) state_d = PAUSE;
          PAUSE: if (ev.start) state_d = RUN;
          FLASH: begin
            if (flash_q == 6'd0) begin
              state_d = IDLE;
              speed_d = 3'd1;
              phase_d = 6'd0;
            end else begin
              flash_d = flash_q - 6'd1;
            end
          end
        endcase
      end
      // Advance only on ticks that land in RUN, using the pre-tick speed.
      if (state_d == RUN) begin
        phase_d = phase_q + {3'b000, speed_q};
      end
    end
  end

  logic [10:0] col_ext;
  logic [10:0] dash_pos;
  logic        hit;

  assign col_ext  = {1'b0, col};
  assign dash_pos = ({1'b0, row} + {5'b00000, phase_q}) & 11'(DASH_PERIOD - 1);
  assign hit      = valid && (col_ext > 11'(LANE_BEGIN))
                    && (col_ext < 11'(LANE_BEGIN + LANE_WIDTH))
                    && (dash_pos < 11'(DASH_LEN));

  always_comb begin
    rgb_d = COLOR_BLACK;
    if (hit) begin
      rgb_d = (state_q == FLASH && flash_q[3]) ? COLOR_RED : COLOR_YELLOW;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= 6'd0;
      speed_q <= 3'd1;
      flash_q <= 6'd0;
      rgb_q   <= COLOR_BLACK;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      speed_q <= speed_d;
      flash_q <= flash_d;
      rgb_q   <= rgb_d;
    end
  end

  assign lane_rgb = rgb_q;
  assign phase    = phase_q;
  assign speed    = speed_q;
  assign state    = state_q;

endmodule

// File: tb/tb_lane_scroll_ctrl.sv
// Directed self-checking bench for lane_scroll_ctrl.
module tb_lane_scroll_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] col, row;
  logic       valid, start, pause, speed_up, speed_dn, crash;
  logic [5:0] lane_rgb, phase;
  logic [2:0] speed;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  localparam logic [5:0] YEL = 6'b111100;
  localparam logic [5:0] RED = 6'b110000;

  lane_scroll_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col      (col),
    .row      (row),
    .valid    (valid),
    .start    (start),
    .pause    (pause),
    .speed_up (speed_up),
    .speed_dn (speed_dn),
    .crash    (crash),
    .lane_rgb (lane_rgb),
    .phase    (phase),
    .speed    (speed),
    .state    (state)
  );

  always #5 clk = ~clk;

  // All stimulus tasks start and end at a negedge.
  task automatic do_tick();
    row = 10'd480; col = 10'd0; valid = 1'b0;
    @(negedge clk);
    row = 10'd0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic do_pulse(input int which);
    case (which)
      0: start = 1'b1;
      1: pause = 1'b1;
      2: speed_up = 1'b1;
      3: speed_dn = 1'b1;
      default: crash = 1'b1;
    endcase
    col = 10'd5;
    @(negedge clk);
    {start, pause, speed_up, speed_dn, crash} = '0;
    col = 10'd0;
  endtask

  task automatic sample_pixel(input int c, input int r, input logic v, output logic [5:0] rgb);
    col = c[9:0]; row = r[9:0]; valid = v;
    @(negedge clk);
    rgb = lane_rgb;
    valid = 1'b0; col = 10'd0; row = 10'd0;
  endtask

  task automatic test_reset();
    logic [5:0] rgb;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (phase !== 6'd0) begin failures++; $display("FAIL reset_phase got=%0d exp=0", phase); end
    checks++; if (speed !== 3'd1) begin failures++; $display("FAIL reset_speed got=%0d exp=1", speed); end
    checks++; if (lane_rgb !== 6'd0) begin failures++; $display("FAIL reset_rgb got=%b exp=000000", lane_rgb); end
    rst_n = 1'b1;
    do_ticks(2);
    checks++; if (state !== 2'd0 || phase !== 6'd0 || speed !== 3'd1) begin
      failures++; $display("FAIL idle_frames got=%0d/%0d/%0d exp=0/0/1", state, phase, speed);
    end
    sample_pixel(290, 10, 1'b1, rgb);
    checks++; if (rgb !== YEL) begin failures++; $display("FAIL idle_pixel got=%b exp=%b", rgb, YEL); end
  endtask

  task automatic test_run_speed();
    logic [5:0] rgb;
    do_pulse(0);
    do_tick();                 // IDLE->RUN, phase 1
    do_pulse(2);
    do_ticks(3);               // phase 2 (speed 2), 4, 6
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL run_state got=%0d exp=1", state); end
    checks++; if (speed !== 3'd2) begin failures++; $display("FAIL run_speed got=%0d exp=2", speed); end
    checks++; if (phase !== 6'd6) begin failures++; $display("FAIL run_phase got=%0d exp=6", phase); end
    sample_pixel(290, 26, 1'b1, rgb);
    checks++; if (rgb !== 6'd0) begin failures++; $display("FAIL dash_off_row got=%b exp=000000", rgb); end
    sample_pixel(290, 25, 1'b1, rgb);
    checks++; if (rgb !== YEL) begin failures++; $display("FAIL dash_on_row got=%b exp=%b", rgb, YEL); end
  endtask

  task automatic test_wrap_bounds();
    logic [5:0] rgb;
    do_pulse(2); do_tick();    // phase 8, speed 3
    do_tick();                 // phase 11
    do_pulse(2); do_tick();    // phase 14, speed 4
    do_ticks(12);              // phase 62
    checks++; if (phase !== 6'd62 || speed !== 3'd4) begin
      failures++; $display("FAIL pre_wrap got=%0d/%0d exp=62/4", phase, speed);
    end
    do_tick();
    checks++; if (phase !== 6'd2) begin failures++; $display("FAIL wrap_phase got=%0d exp=2", phase); end
    sample_pixel(275, 0, 1'b1, rgb);
    checks++; if (rgb !== 6'd0) begin failures++; $display("FAIL col_275 got=%b exp=000000", rgb); end
    sample_pixel(310, 0, 1'b1, rgb);
    checks++; if (rgb !== 6'd0) begin failures++; $display("FAIL col_310 got=%b exp=000000", rgb); end
    sample_pixel(276, 0, 1'b1, rgb);
    checks++; if (rgb !== YEL) begin failures++; $display("FAIL col_276 got=%b exp=%b", rgb, YEL); end
    sample_pixel(309, 0, 1'b1, rgb);
    checks++; if (rgb !== YEL) begin failures++; $display("FAIL col_309 got=%b exp=%b", rgb, YEL); end
    sample_pixel(290, 0, 1'b0, rgb);
    checks++; if (rgb !== 6'd0) begin failures++; $display("FAIL invalid_pix got=%b exp=000000", rgb); end
    sample_pixel(290, 62, 1'b1, rgb);   // (62+2) mod 64 = 0
    checks++; if (rgb !== YEL) begin failures++; $display("FAIL row_wrap got=%b exp=%b", rgb, YEL); end
    sample_pixel(290, 30, 1'b1, rgb);   // 32 is the first dark row
    checks++; if (rgb !== 6'd0) begin failures++; $display("FAIL row_30 got=%b exp=000000", rgb); end
  endtask

  task automatic test_speed_limits();
    speed_up = 1'b1; speed_dn = 1'b1;
    @(negedge clk);
    speed_up = 1'b0; speed_dn = 1'b0;
    do_tick();                 // phase 6, speed 4
    checks++; if (speed !== 3'd4 || phase !== 6'd6) begin
      failures++; $display("FAIL up_dn_cancel got=%0d/%0d exp=4/6", speed, phase);
    end
    for (int i = 0; i < 8; i++) begin do_pulse(2); do_tick(); end
    checks++; if (speed !== 3'd7 || phase !== 6'd56) begin
      failures++; $display("FAIL speed_max got=%0d/%0d exp=7/56", speed, phase);
    end
    for (int i = 0; i < 8; i++) begin do_pulse(3); do_tick(); end
    checks++; if (speed !== 3'd0 || phase !== 6'd20) begin
      failures++; $display("FAIL speed_min got=%0d/%0d exp=0/20", speed, phase);
    end
    do_tick();
    checks++; if (state !== 2'd1 || phase !== 6'd20) begin
      failures++; $display("FAIL zero_speed_hold got=%0d/%0d exp=1/20", state, phase);
    end
  endtask

  task automatic test_crash_flash();
    logic [5:0] rgb;
    do_pulse(1);
    do_pulse(4);
    do_tick();                 // FLASH, counter 59
    checks++; if (state !== 2'd3 || phase !== 6'd20) begin
      failures++; $display("FAIL crash_enter got=%0d/%0d exp=3/20", state, phase);
    end
    sample_pixel(290, 0, 1'b1, rgb);
    checks++; if (rgb !== RED) begin failures++; $display("FAIL flash_cnt59 got=%b exp=%b", rgb, RED); end
    do_ticks(4);               // counter 55
    sample_pixel(290, 0, 1'b1, rgb);
    checks++; if (rgb !== YEL) begin failures++; $display("FAIL flash_cnt55 got=%b exp=%b", rgb, YEL); end
    do_ticks(8);               // counter 47
    sample_pixel(290, 0, 1'b1, rgb);
    checks++; if (rgb !== RED) begin failures++; $display("FAIL flash_cnt47 got=%b exp=%b", rgb, RED); end
    do_ticks(47);              // counter 0, still flashing
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL flash_last got=%0d exp=3", state); end
    do_tick();
    checks++; if (state !== 2'd0 || phase !== 6'd0 || speed !== 3'd1) begin
      failures++; $display("FAIL flash_exit got=%0d/%0d/%0d exp=0/0/1", state, phase, speed);
    end
  endtask

  task automatic test_reset_midrun();
    do_pulse(0);
    do_tick();                 // RUN, phase 1
    checks++; if (state !== 2'd1 || phase !== 6'd1) begin
      failures++; $display("FAIL rerun got=%0d/%0d exp=1/1", state, phase);
    end
    do_pulse(2);
    do_pulse(4);
    col = 10'd290; row = 10'd200; valid = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; valid = 1'b0; col = 10'd0; row = 10'd0;
    checks++; if (state !== 2'd0 || phase !== 6'd0 || speed !== 3'd1) begin
      failures++; $display("FAIL midrun_reset got=%0d/%0d/%0d exp=0/0/1", state, phase, speed);
    end
    checks++; if (lane_rgb !== 6'd0) begin failures++; $display("FAIL midrun_rgb got=%b exp=000000", lane_rgb); end
    do_tick();
    checks++; if (state !== 2'd0 || speed !== 3'd1) begin
      failures++; $display("FAIL stale_events got=%0d/%0d exp=0/1", state, speed);
    end
  endtask

  initial begin
    rst_n = 1'b0; col = '0; row = '0; valid = 1'b0;
    {start, pause, speed_up, speed_dn, crash} = '0;
    @(negedge clk);
    test_reset();
    test_run_speed();
    test_wrap_bounds();
    test_speed_limits();
    test_crash_flash();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
